sram_arbiter: RTL and testbench

Shares the single external 8-bit SRAM (ramWe/ramD/ramA) between three requesters: the video fetcher (read-only), the boot/ROM loader (write-only) and the CPU (read/write). It sits between those clients and the SRAM pins in the zx48 top level. It replaces direct pin driving with a req/ack handshake, a fixed-priority scheme with a CPU anti-starvation counter, and SRAM strobe sequencing that avoids data-bus contention.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Package   : sram_pkg
// Purpose   : Shared constants for the external SRAM arbiter: controller
//             state encoding, requester identifiers and default address width.
// Revision  : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int AW_DEFAULT = 21;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam logic [1:0] REQ_VID = 2'd0;
    localparam logic [1:0] REQ_LDR = 2'd1;
    localparam logic [1:0] REQ_CPU = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : sram_arbiter
// Purpose   : Shares one 8-bit asynchronous SRAM between video (read), loader
//             (write) and CPU (read/write) with req/ack handshakes.
// Revision  : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int AW     = AW_DEFAULT,
    parameter int STARVE = 4
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          vidReq,
    input  logic [AW-1:0] vidA,
    output logic          vidAck,
    output logic [7:0]    vidQ,

    input  logic          ldrReq,
    input  logic [AW-1:0] ldrA,
    input  logic [7:0]    ldrD,
    output logic          ldrAck,

    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic          cpuAck,
    output logic [7:0]    cpuQ,

    output logic          ramWe,
    inout  wire  [7:0]    ramD,
    output logic [AW-1:0] ramA,
    output logic          busy
);

    localparam logic [3:0] c_STARVE = 4'(STARVE);

    logic [1:0]    r_state;
    logic [1:0]    r_id;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;
    logic          r_write;
    logic          r_ramWe;
    logic          r_drive;
    logic          r_vidAck;
    logic          r_ldrAck;
    logic          r_cpuAck;
    logic [7:0]    r_vidQ;
    logic [7:0]    r_cpuQ;
    logic [3:0]    r_starve;

    logic          w_vidEff;
    logic          w_ldrEff;
    logic          w_cpuEff;
    logic          w_force;
    logic          w_grant;
    logic [1:0]    w_gntId;

    // A requester being acked this cycle still shows req high; mask it out.
    assign w_vidEff = vidReq & ~r_vidAck;
    assign w_ldrEff = ldrReq & ~r_ldrAck;
    assign w_cpuEff = cpuReq & ~r_cpuAck;
    assign w_force  = w_cpuEff && (r_starve == c_STARVE);

    always_comb begin
        w_grant = 1'b0;
        w_gntId = REQ_VID;
        if (r_state == ST_IDLE) begin
            if (w_force) begin
                w_grant = 1'b1;
                w_gntId = REQ_CPU;
            end else if (w_vidEff) begin
                w_grant = 1'b1;
                w_gntId = REQ_VID;
            end else if (w_ldrEff) begin
                w_grant = 1'b1;
                w_gntId = REQ_LDR;
            end else if (w_cpuEff) begin
                w_grant = 1'b1;
                w_gntId = REQ_CPU;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_id     <= REQ_VID;
            r_addr   <= '0;
            r_data   <= 8'h00;
            r_write  <= 1'b0;
            r_ramWe  <= 1'b1;
            r_drive  <= 1'b0;
            r_vidAck <= 1'b0;
            r_ldrAck <= 1'b0;
            r_cpuAck <= 1'b0;
            r_vidQ   <= 8'h00;
            r_cpuQ   <= 8'h00;
        end else begin
            r_vidAck <= 1'b0;
            r_ldrAck <= 1'b0;
            r_cpuAck <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_id    <= w_gntId;
                        r_state <= ST_SETUP;
                        case (w_gntId)
                            REQ_VID: begin
                                r_addr  <= vidA;
                                r_write <= 1'b0;
                            end
                            REQ_LDR: begin
                                r_addr  <= ldrA;
                                r_data  <= ldrD;
                                r_write <= 1'b1;
                            end
                            default: begin
                                r_addr  <= cpuA;
                                r_data  <= cpuD;
                                r_write <= cpuWe;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    if (r_write) begin
                        r_ramWe <= 1'b0;
                        r_drive <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    // Release the bus on the same edge that ends the write pulse.
                    r_ramWe <= 1'b1;
                    r_drive <= 1'b0;
                    if (r_write) begin
                        r_state <= ST_RECOVER;
                    end else begin
                        r_state <= ST_IDLE;
                        if (r_id == REQ_VID) begin
                            r_vidQ   <= ramD;
                            r_vidAck <= 1'b1;
                        end else begin
                            r_cpuQ   <= ramD;
                            r_cpuAck <= 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    case (r_id)
                        REQ_VID: r_vidAck <= 1'b1;
                        REQ_LDR: r_ldrAck <= 1'b1;
                        default: r_cpuAck <= 1'b1;
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (!w_cpuEff || (w_grant && (w_gntId == REQ_CPU))) begin
            r_starve <= 4'd0;
        end else if (w_grant && (r_starve != c_STARVE)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign ramD   = r_drive ? r_data : 8'bz;
    assign ramWe  = r_ramWe;
    assign ramA   = r_addr;
    assign busy   = (r_state != ST_IDLE);
    assign vidAck = r_vidAck;
    assign ldrAck = r_ldrAck;
    assign cpuAck = r_cpuAck;
    assign vidQ   = r_vidQ;
    assign cpuQ   = r_cpuQ;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_sram_arbiter
// Purpose   : Bench for sram_arbiter: timestamp-based transaction model, SRAM
//             emulation, directed cases and a randomized request phase.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_pkg::*;

    localparam int AW     = 21;
    localparam int STARVE = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vidReq = 1'b0, ldrReq = 1'b0, cpuReq = 1'b0, cpuWe = 1'b0;
    logic [AW-1:0] vidA = '0, ldrA = '0, cpuA = '0;
    logic [7:0]    ldrD = 8'h00, cpuD = 8'h00;
    logic          vidAck, ldrAck, cpuAck, ramWe, busy;
    logic [7:0]    vidQ, cpuQ;
    logic [AW-1:0] ramA;
    wire  [7:0]    ramD;

    always #5 clock = ~clock;

    sram_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clock(clock), .reset(reset),
        .vidReq(vidReq), .vidA(vidA), .vidAck(vidAck), .vidQ(vidQ),
        .ldrReq(ldrReq), .ldrA(ldrA), .ldrD(ldrD), .ldrAck(ldrAck),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD),
        .cpuAck(cpuAck), .cpuQ(cpuQ),
        .ramWe(ramWe), .ramD(ramD), .ramA(ramA), .busy(busy)
    );

    // SRAM emulation: output enabled whenever not writing, aliased on 8 address bits.
    logic [7:0] sram [256];
    assign ramD = ramWe ? sram[ramA[7:0]] : 8'bz;
    always @(negedge clock) if (!reset && !ramWe) sram[ramA[7:0]] <= ramD;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each grant fixes every pin event by timestamp.
    logic          mValid = 1'b0, mWr = 1'b0;
    logic [1:0]    mId = REQ_VID;
    logic [AW-1:0] mAddr = '0, mRamA = '0;
    logic [7:0]    mData = 8'h00, mVidQ = 8'h00, mCpuQ = 8'h00;
    logic [7:0]    mMem [256];
    int            mG = 0, mAckCyc = 0, mFree = 0, mStarve = 0;
    int            ackId [$];
    int            ackCyc [$];
    int            weLow = 0;

    always @(negedge clock) begin
        logic eV, eL, eC, eWe, vE, lE, cE;
        int   c, gid;
        if (reset) begin
            mValid = 1'b0; mFree = 0; mStarve = 0; mRamA = '0;
            mVidQ = 8'h00; mCpuQ = 8'h00;
        end else begin
            c  = cyc;
            eV = mValid && c == mAckCyc && mId == REQ_VID;
            eL = mValid && c == mAckCyc && mId == REQ_LDR;
            eC = mValid && c == mAckCyc && mId == REQ_CPU;
            if (mValid && c == mAckCyc && !mWr) begin
                if (mId == REQ_VID) mVidQ = mMem[mAddr[7:0]];
                else                mCpuQ = mMem[mAddr[7:0]];
            end
            eWe = !(mValid && mWr && c == mG + 2);
            chk("busy",   32'(busy),   32'(c < mFree));
            chk("ramWe",  32'(ramWe),  32'(eWe));
            chk("ramA",   32'(ramA),   32'(mRamA));
            chk("vidAck", 32'(vidAck), 32'(eV));
            chk("ldrAck", 32'(ldrAck), 32'(eL));
            chk("cpuAck", 32'(cpuAck), 32'(eC));
            chk("vidQ",   32'(vidQ),   32'(mVidQ));
            chk("cpuQ",   32'(cpuQ),   32'(mCpuQ));
            if (!eWe) begin
                chk("ramD", 32'(ramD), 32'(mData));
                mMem[mAddr[7:0]] = mData;
            end
            if (!ramWe) weLow++;
            if (vidAck) begin ackId.push_back(0); ackCyc.push_back(c); end
            if (ldrAck) begin ackId.push_back(1); ackCyc.push_back(c); end
            if (cpuAck) begin ackId.push_back(2); ackCyc.push_back(c); end

            vE = vidReq && !eV;
            lE = ldrReq && !eL;
            cE = cpuReq && !eC;
            gid = -1;
            if (c >= mFree) begin
                if (cE && mStarve == STARVE) gid = 2;
                else if (vE)                 gid = 0;
                else if (lE)                 gid = 1;
                else if (cE)                 gid = 2;
            end
            if (!cE || gid == 2)  mStarve = 0;
            else if (gid >= 0)    mStarve = (mStarve < STARVE) ? mStarve + 1 : STARVE;
            if (gid >= 0) begin
                mValid = 1'b1;
                mId    = 2'(gid);
                mG     = c;
                case (gid)
                    0:       begin mAddr = vidA; mWr = 1'b0; end
                    1:       begin mAddr = ldrA; mWr = 1'b1; mData = ldrD; end
                    default: begin mAddr = cpuA; mWr = cpuWe; mData = cpuD; end
                endcase
                mAckCyc = c + (mWr ? 4 : 3);
                mFree   = mAckCyc;
                mRamA   = mAddr;
            end
        end
    end

    function automatic logic ackOf(input int id);
        return (id == 0) ? vidAck : (id == 1) ? ldrAck : cpuAck;
    endfunction

    task automatic dropReq(input int id);
        if (id == 0) vidReq = 1'b0;
        else if (id == 1) ldrReq = 1'b0;
        else cpuReq = 1'b0;
    endtask

    task automatic waitAck(input int id, input int budget, input bit drop, output int when);
        when = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clock); #1;
            if (ackOf(id)) begin when = cyc; break; end
        end
        if (when < 0) begin
            nCmp++; nBad++;
            $display("FAIL waitAck id %0d: no ack within %0d cycles, required one", id, budget);
        end else if (drop) begin
            @(posedge clock); #1;
            dropReq(id);
        end
    endtask

    initial begin
        int n, t, t1, t2, tv, tl, tc, w0, q0;
        bit dV, dL, dC;
        for (int i = 0; i < 256; i++) begin
            sram[i] = 8'($urandom);
            mMem[i] = sram[i];
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy",  32'(busy),   0);
        chk("rst_ramWe", 32'(ramWe),  1);
        chk("rst_ramA",  32'(ramA),   0);
        chk("rst_acks",  32'({vidAck, ldrAck, cpuAck}), 0);
        chk("rst_vidQ",  32'(vidQ),   0);
        chk("rst_cpuQ",  32'(cpuQ),   0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // CPU write then read back
        n = cyc; w0 = weLow;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h04000; cpuD = 8'h5A;
        waitAck(2, 20, 1'b1, t);
        chk("cpuWrLat", 32'(t - n), 4);
        chk("weLowCycles", 32'(weLow - w0), 1);
        n = cyc;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h04000;
        waitAck(2, 20, 1'b1, t);
        chk("cpuRdLat", 32'(t - n), 3);
        chk("cpuRdData", 32'(cpuQ), 32'h5A);

        // Simultaneous requests
        n = cyc;
        vidReq = 1'b1; vidA = 21'h04000;
        ldrReq = 1'b1; ldrA = 21'h00000; ldrD = 8'hF3;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h00000;
        waitAck(0, 20, 1'b1, tv);
        waitAck(1, 20, 1'b1, tl);
        waitAck(2, 20, 1'b1, tc);
        chk("simVidAck", 32'(tv - n), 3);
        chk("simLdrAck", 32'(tl - n), 7);
        chk("simCpuAck", 32'(tc - n), 10);
        chk("simVidQ", 32'(vidQ), 32'h5A);
        chk("simCpuQ", 32'(cpuQ), 32'hF3);

        // Held-high video request
        n = cyc;
        vidReq = 1'b1; vidA = 21'h00000;
        waitAck(0, 20, 1'b0, t1);
        waitAck(0, 20, 1'b0, t2);
        vidReq = 1'b0;
        chk("holdFirst", 32'(t1 - n), 3);
        chk("holdSpacing", 32'(t2 - t1), 4);
        repeat (4) @(posedge clock);
        #1;

        // Starvation: vid and ldr held high, CPU forced through after STARVE grants
        q0 = ackId.size(); n = cyc;
        vidReq = 1'b1; vidA = 21'h00010;
        ldrReq = 1'b1; ldrA = 21'h00020; ldrD = 8'h3C;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h00020;
        for (int k = 0; k < 60 && ackId.size() < q0 + 5; k++) begin
            @(posedge clock); #1;
        end
        vidReq = 1'b0; ldrReq = 1'b0; cpuReq = 1'b0;
        if (ackId.size() < q0 + 5) begin
            nCmp++; nBad++;
            $display("FAIL starve: %0d acks seen, required 5", ackId.size() - q0);
        end else begin
            chk("starveOrder", 32'({ackId[q0][3:0], ackId[q0+1][3:0], ackId[q0+2][3:0],
                                    ackId[q0+3][3:0], ackId[q0+4][3:0]}), 32'h01012);
            chk("starveCpuCyc", 32'(ackCyc[q0+4] - n), 17);
            chk("starveCpuQ", 32'(cpuQ), 32'h3C);
        end
        repeat (8) @(posedge clock);
        #1;

        // Reset during STROBE of a CPU write
        q0 = ackId.size();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h00100; cpuD = 8'h77;
        repeat (2) @(posedge clock);
        #1;
        chk("midWrWeLow", 32'(ramWe), 0);
        reset = 1'b1; cpuReq = 1'b0;
        #1;
        chk("midRstWe", 32'(ramWe), 1);
        chk("midRstBusy", 32'(busy), 0);
        chk("midRstAck", 32'(cpuAck), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("midRstNoAck", 32'(ackId.size() - q0), 0);

        // Randomized traffic
        dV = 0; dL = 0; dC = 0;
        for (int k = 0; k < 2500; k++) begin
            @(posedge clock); #1;
            if (dV) vidReq = 1'b0;
            if (dL) ldrReq = 1'b0;
            if (dC) cpuReq = 1'b0;
            dV = vidAck; dL = ldrAck; dC = cpuAck;
            if (!vidReq && !dV && $urandom_range(0, 3) == 0) begin
                vidReq = 1'b1; vidA = AW'($urandom);
            end
            if (!ldrReq && !dL && $urandom_range(0, 4) == 0) begin
                ldrReq = 1'b1; ldrA = AW'($urandom); ldrD = 8'($urandom);
            end
            if (!cpuReq && !dC && $urandom_range(0, 2) == 0) begin
                cpuReq = 1'b1; cpuWe = 1'($urandom); cpuA = AW'($urandom); cpuD = 8'($urandom);
            end
        end
        for (int k = 0; k < 200 && (vidReq || ldrReq || cpuReq); k++) begin
            @(posedge clock); #1;
            if (dV) vidReq = 1'b0;
            if (dL) ldrReq = 1'b0;
            if (dC) cpuReq = 1'b0;
            dV = vidAck; dL = ldrAck; dC = cpuAck;
        end
        chk("drained", 32'({vidReq, ldrReq, cpuReq}), 0);
        vidReq = 1'b0; ldrReq = 1'b0; cpuReq = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
